ahb_master_arbiter: RTL and testbench



---
 rtl/ahb_master_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB bus arbiter for 2..4 masters; locked transfers only when AHB_ARB_LOCK_EN is defined.
// Latency: grant/HMASTER registered one cycle after a handover point; backpressure: HREADY=0 freezes grant, counter and HMASTERD.
module ahb_master_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HREADY,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCKREQ,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [1:0]             HMASTER,
    output logic [1:0]             HMASTERD,
    output logic                   HMASTLOCK
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;
    localparam logic [2:0] HB_WRAP4  = 3'd2;
    localparam logic [2:0] HB_INCR4  = 3'd3;
    localparam logic [2:0] HB_WRAP8  = 3'd4;
    localparam logic [2:0] HB_INCR8  = 3'd5;
    localparam logic [2:0] HB_WRAP16 = 3'd6;
    localparam logic [2:0] HB_INCR16 = 3'd7;

    localparam logic [1:0]             DEF_IDX   = 2'(DEFAULT_MASTER);
    localparam logic [2:0]             NM        = 3'(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] GRANT_DEF = NUM_MASTERS'(1) << DEFAULT_MASTER;

`ifdef AHB_ARB_LOCK_EN
    typedef enum logic [1:0] {ST_OWN, ST_BURST, ST_LOCKED} state_t;
`else
    typedef enum logic [0:0] {ST_OWN, ST_BURST} state_t;
`endif

    state_t                 state;
    logic [4:0]             cnt;
    logic [4:0]             cnt_nxt;
    logic [4:0]             burst_len;
    logic [1:0]             ptr;
    logic [1:0]             winner;
    logic [2:0]             idx;
    logic                   found;
    logic                   hop;
    logic                   owner_req;
    logic [3:0]             req_pad;
    logic [NUM_MASTERS-1:0] grant_nxt;
    logic                   is_idle;
    logic                   is_busy;
    logic                   is_nonseq;
    logic                   is_seq;

    assign is_idle   = (HTRANS == HT_IDLE);
    assign is_busy   = (HTRANS == HT_BUSY);
    assign is_nonseq = (HTRANS == HT_NONSEQ);
    assign is_seq    = (HTRANS == HT_SEQ);

    always_comb begin
        req_pad                  = '0;
        req_pad[NUM_MASTERS-1:0] = HBUSREQ;
    end

    assign owner_req = req_pad[HMASTER];

    always_comb begin
        burst_len = 5'd0;
        case (HBURST)
            HB_WRAP4,  HB_INCR4:  burst_len = 5'd3;
            HB_WRAP8,  HB_INCR8:  burst_len = 5'd7;
            HB_WRAP16, HB_INCR16: burst_len = 5'd15;
            default:              burst_len = 5'd0;
        endcase
    end

    // Counter holds remaining SEQ beats of a fixed burst; value 1 marks the last beat.
    always_comb begin
        cnt_nxt = cnt;
        if (HREADY && is_nonseq)
            cnt_nxt = burst_len;
        else if (HREADY && is_seq && cnt != 5'd0)
            cnt_nxt = cnt - 5'd1;
    end

    always_comb begin
        hop = 1'b0;
        if (HREADY) begin
            case (state)
                ST_OWN: hop = is_idle
                           || (is_nonseq && HBURST == HB_SINGLE)
                           || (is_seq && cnt == 5'd1)
                           || (HBURST == HB_INCR && !owner_req && !is_busy);
                ST_BURST: hop = is_seq && cnt == 5'd1;
                default:  hop = 1'b0;
            endcase
        end
    end

    // Scan from pointer+1 so the current owner is considered last.
    always_comb begin
        winner = DEF_IDX;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= 4; i++) begin
            if (i <= NUM_MASTERS) begin
                idx = {1'b0, ptr} + 3'(i);
                if (idx >= NM)
                    idx = idx - NM;
                if (!found && req_pad[idx[1:0]]) begin
                    winner = idx[1:0];
                    found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_nxt         = '0;
        grant_nxt[winner] = 1'b1;
    end

`ifdef AHB_ARB_LOCK_EN
    logic [3:0] lock_pad;
    logic       lock_grant;
    logic       lock_release;

    always_comb begin
        lock_pad                  = '0;
        lock_pad[NUM_MASTERS-1:0] = HLOCKREQ;
    end

    assign lock_grant   = req_pad[winner] && lock_pad[winner];
    assign lock_release = HREADY && is_idle && !lock_pad[HMASTER];
`else
    logic unused_lockreq;
    assign unused_lockreq = ^HLOCKREQ;
    assign HMASTLOCK      = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_OWN;
            cnt      <= 5'd0;
            ptr      <= DEF_IDX;
            HGRANT   <= GRANT_DEF;
            HMASTER  <= DEF_IDX;
            HMASTERD <= DEF_IDX;
`ifdef AHB_ARB_LOCK_EN
            HMASTLOCK <= 1'b0;
`endif
        end else begin
            cnt <= cnt_nxt;
            if (HREADY)
                HMASTERD <= HMASTER;
            if (hop) begin
                HGRANT  <= grant_nxt;
                HMASTER <= winner;
                ptr     <= winner;
            end
`ifdef AHB_ARB_LOCK_EN
            // Leaving LOCKED does not arbitrate: the owner keeps one more IDLE cycle.
            if (state == ST_LOCKED) begin
                if (lock_release) begin
                    state     <= ST_OWN;
                    HMASTLOCK <= 1'b0;
                end
            end else if (hop && lock_grant) begin
                state     <= ST_LOCKED;
                HMASTLOCK <= 1'b1;
            end else begin
                state <= (cnt_nxt != 5'd0) ? ST_BURST : ST_OWN;
            end
`else
            state <= (cnt_nxt != 5'd0) ? ST_BURST : ST_OWN;
`endif
        end
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: parking, round robin, fixed/undefined bursts, reset, lock.
module tb_ahb_master_arbiter;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] INCR8  = 3'd5;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       HREADY;
    logic [2:0] HBUSREQ;
    logic [2:0] HLOCKREQ;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic [2:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTERD;
    logic       HMASTLOCK;

    int checks = 0;
    int errors = 0;
    int prev;
    int rr_exp [6] = '{1, 2, 0, 1, 2, 0};

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter #(
        .NUM_MASTERS   (3),
        .DEFAULT_MASTER(0)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HREADY   (HREADY),
        .HBUSREQ  (HBUSREQ),
        .HLOCKREQ (HLOCKREQ),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTERD (HMASTERD),
        .HMASTLOCK(HMASTLOCK)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_own(input string tag, input int m);
        chk({tag, "_grant"}, 32'(HGRANT), 1 << m);
        chk({tag, "_master"}, 32'(HMASTER), m);
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic rdy, input logic [2:0] req, input logic [2:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu);
        HREADY   = rdy;
        HBUSREQ  = req;
        HLOCKREQ = lck;
        HTRANS   = tr;
        HBURST   = bu;
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        HRESET   = 1'b1;
        HREADY   = 1'b1;
        HBUSREQ  = 3'b000;
        HLOCKREQ = 3'b000;
        HTRANS   = IDLE;
        HBURST   = SINGLE;
        repeat (2) @(posedge HCLK);
        #1;
        chk_own("reset", 0);
        chk("reset_masterd", 32'(HMASTERD), 0);
        chk("reset_mastlock", 32'(HMASTLOCK), 0);
        HRESET = 1'b0;

        // Parked on the default master with no requests
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 3'b000, 3'b000, IDLE, SINGLE);
            chk_own("park", 0);
            chk("park_masterd", 32'(HMASTERD), 0);
            chk("park_mastlock", 32'(HMASTLOCK), 0);
        end

        // Round robin on SINGLE transfers, every cycle a handover point
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 3'b111, 3'b000, NONSEQ, SINGLE);
            chk_own("rr", rr_exp[k]);
            chk("rr_masterd", 32'(HMASTERD), prev);
            prev = rr_exp[k];
        end

        // INCR4 by master 1, master 2 waiting, two wait states on beat 2
        cyc(1'b1, 3'b010, 3'b000, IDLE, SINGLE);
        chk_own("incr4_gnt", 1);
        cyc(1'b1, 3'b110, 3'b000, NONSEQ, INCR4);
        chk_own("incr4_b1", 1);
        cyc(1'b0, 3'b110, 3'b000, SEQ, INCR4);
        chk_own("incr4_ws1", 1);
        cyc(1'b0, 3'b110, 3'b000, SEQ, INCR4);
        chk_own("incr4_ws2", 1);
        cyc(1'b1, 3'b110, 3'b000, SEQ, INCR4);
        chk_own("incr4_b2", 1);
        cyc(1'b1, 3'b110, 3'b000, SEQ, INCR4);
        chk_own("incr4_b3", 1);
        cyc(1'b1, 3'b110, 3'b000, SEQ, INCR4);
        chk_own("incr4_b4", 2);
        chk("incr4_b4_masterd", 32'(HMASTERD), 1);
        cyc(1'b0, 3'b100, 3'b000, NONSEQ, SINGLE);
        chk("incr4_hold_masterd", 32'(HMASTERD), 1);
        chk_own("incr4_hold", 2);
        cyc(1'b1, 3'b100, 3'b000, NONSEQ, SINGLE);
        chk("incr4_next_masterd", 32'(HMASTERD), 2);
        chk_own("incr4_next", 2);

        // Requests without HREADY wait; then master 0 takes the bus
        cyc(1'b0, 3'b001, 3'b000, IDLE, SINGLE);
        chk_own("ws_no_hop", 2);
        cyc(1'b1, 3'b001, 3'b000, IDLE, SINGLE);
        chk_own("ws_hop", 0);

        // Undefined INCR by master 0 with master 2 requesting; BUSY never hands over
        cyc(1'b1, 3'b101, 3'b000, NONSEQ, INCR);
        chk_own("incr_b1", 0);
        cyc(1'b1, 3'b101, 3'b000, SEQ, INCR);
        chk_own("incr_b2", 0);
        cyc(1'b1, 3'b101, 3'b000, BUSY, INCR);
        chk_own("incr_busy", 0);
        cyc(1'b1, 3'b101, 3'b000, SEQ, INCR);
        chk_own("incr_b3", 0);
        cyc(1'b1, 3'b101, 3'b000, SEQ, INCR);
        chk_own("incr_b4", 0);
        cyc(1'b1, 3'b100, 3'b000, BUSY, INCR);
        chk_own("incr_busy_drop", 0);
        cyc(1'b1, 3'b100, 3'b000, SEQ, INCR);
        chk_own("incr_b5_drop", 2);

        // Reset in the middle of an INCR8 by master 2
        cyc(1'b1, 3'b110, 3'b000, NONSEQ, INCR8);
        chk_own("incr8_b1", 2);
        cyc(1'b1, 3'b110, 3'b000, SEQ, INCR8);
        chk_own("incr8_b2", 2);
        cyc(1'b1, 3'b110, 3'b000, SEQ, INCR8);
        chk_own("incr8_b3", 2);
        HRESET = 1'b1;
        cyc(1'b1, 3'b110, 3'b000, SEQ, INCR8);
        HRESET = 1'b0;
        chk_own("midrst", 0);
        chk("midrst_masterd", 32'(HMASTERD), 0);
        chk("midrst_mastlock", 32'(HMASTLOCK), 0);
        cyc(1'b1, 3'b010, 3'b000, NONSEQ, SINGLE);
        chk_own("postrst_hop", 1);

        // Master 2 requests with HLOCKREQ while master 1 keeps requesting
        cyc(1'b1, 3'b100, 3'b100, IDLE, SINGLE);
        chk_own("lk_gnt", 2);
`ifdef AHB_ARB_LOCK_EN
        chk("lk_gnt_mastlock", 32'(HMASTLOCK), 1);
        cyc(1'b1, 3'b110, 3'b100, NONSEQ, SINGLE);
        chk_own("lk_s1", 2);
        chk("lk_s1_mastlock", 32'(HMASTLOCK), 1);
        cyc(1'b1, 3'b110, 3'b100, NONSEQ, SINGLE);
        chk_own("lk_s2", 2);
        chk("lk_s2_mastlock", 32'(HMASTLOCK), 1);
        cyc(1'b1, 3'b110, 3'b100, IDLE, SINGLE);
        chk_own("lk_idle_held", 2);
        cyc(1'b1, 3'b110, 3'b000, NONSEQ, SINGLE);
        chk_own("lk_nonseq_rel", 2);
        chk("lk_nonseq_mastlock", 32'(HMASTLOCK), 1);
        cyc(1'b1, 3'b010, 3'b000, IDLE, SINGLE);
        chk_own("lk_release", 2);
        chk("lk_release_mastlock", 32'(HMASTLOCK), 0);
        cyc(1'b1, 3'b010, 3'b000, IDLE, SINGLE);
        chk_own("lk_regrant", 1);
`else
        chk("lk_gnt_mastlock", 32'(HMASTLOCK), 0);
        cyc(1'b1, 3'b110, 3'b100, NONSEQ, SINGLE);
        chk_own("nolk_s1", 1);
        chk("nolk_s1_mastlock", 32'(HMASTLOCK), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
